// File: rtl/alu_issue_pipe.sv
// alu_issue_pipe: two-stage issue (EX) / writeback (WB) pipeline wrapped around an external
// combinational ALU, with an internal register file and a single EX-stage operand bypass.
module alu_issue_pipe #(
    parameter int DATA_W = 16,
    parameter int CODE_W = 5,
    parameter int NREG   = 8,
    localparam int AW    = $clog2(NREG)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              in_ld,
    input  logic [CODE_W-1:0] in_code,
    input  logic [AW-1:0]     in_rd,
    input  logic [AW-1:0]     in_rs1,
    input  logic [AW-1:0]     in_rs2,
    input  logic [DATA_W-1:0] in_imm,
    output logic [DATA_W-1:0] alu_a,
    output logic [DATA_W-1:0] alu_b,
    output logic [CODE_W-1:0] alu_code,
    input  logic [DATA_W-1:0] alu_c,
    input  logic              alu_overflow,
    output logic              wb_valid,
    input  logic              wb_ready,
    output logic [AW-1:0]     wb_rd,
    output logic [DATA_W-1:0] wb_data,
    output logic              wb_overflow,
    output logic              ovf_sticky,
    input  logic              clear_ovf
);

    logic                     vld_p1;
    logic                     ld_p1;
    logic [AW-1:0]            rd_p1;
    logic signed [DATA_W-1:0] res_p1;
    logic                     ovf_p1;
    logic signed [DATA_W-1:0] opa_p0;
    logic signed [DATA_W-1:0] opb_p0;
    logic signed [DATA_W-1:0] rf [NREG];
    logic                     stall;
    logic                     accept;

    assign stall    = wb_valid && !wb_ready;
    assign in_ready = !stall;
    assign accept   = in_valid && in_ready;

    // Result the op in EX will retire with; a load carries its immediate on alu_a.
    assign res_p1 = ld_p1 ? alu_a : alu_c;
    assign ovf_p1 = ld_p1 ? 1'b0 : alu_overflow;

    // ---- stage p0: operand select (RF, or bypass from EX; r0 is hard zero) ----
    always_comb begin
        opa_p0 = '0;
        opb_p0 = '0;
        if (in_ld) begin
            opa_p0 = in_imm;
        end else begin
            if (in_rs1 == '0)
                opa_p0 = '0;
            else if (vld_p1 && rd_p1 == in_rs1)
                opa_p0 = res_p1;
            else
                opa_p0 = rf[in_rs1];

            if (in_rs2 == '0)
                opb_p0 = '0;
            else if (vld_p1 && rd_p1 == in_rs2)
                opb_p0 = res_p1;
            else
                opb_p0 = rf[in_rs2];
        end
    end

    // ---- stage p1: EX registers drive the ALU ----
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_p1   <= 1'b0;
            ld_p1    <= 1'b0;
            rd_p1    <= '0;
            alu_a    <= '0;
            alu_b    <= '0;
            alu_code <= '0;
        end else if (!stall) begin
            vld_p1 <= accept;
            if (accept) begin
                ld_p1    <= in_ld;
                rd_p1    <= in_rd;
                alu_code <= in_code;
                alu_a    <= opa_p0;
                alu_b    <= opb_p0;
            end
        end
    end

    // ---- stage p2: WB record capture and sticky overflow (set beats clear) ----
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wb_valid    <= 1'b0;
            wb_rd       <= '0;
            wb_data     <= '0;
            wb_overflow <= 1'b0;
            ovf_sticky  <= 1'b0;
        end else begin
            if (!stall) begin
                wb_valid <= vld_p1;
                if (vld_p1) begin
                    wb_rd       <= rd_p1;
                    wb_data     <= res_p1;
                    wb_overflow <= ovf_p1;
                end
            end
            if (!stall && vld_p1 && ovf_p1)
                ovf_sticky <= 1'b1;
            else if (clear_ovf)
                ovf_sticky <= 1'b0;
        end
    end

    // Register file is written at WB capture, so it already holds every WB-stage result.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NREG; i++)
                rf[i] <= '0;
        end else if (!stall && vld_p1 && rd_p1 != '0) begin
            rf[rd_p1] <= res_p1;
        end
    end

endmodule

// File: tb/tb_alu_issue_pipe.sv
// Bench for alu_issue_pipe: behavioural ALU, reference register file and an in-order
// scoreboard of expected writeback records, plus per-scenario timing/stability checks.
module tb_alu_issue_pipe;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid, in_ready, in_ld;
    logic [4:0]  in_code;
    logic [2:0]  in_rd, in_rs1, in_rs2;
    logic [15:0] in_imm;
    logic [15:0] alu_a, alu_b, alu_c;
    logic [4:0]  alu_code;
    logic        alu_overflow;
    logic        wb_valid, wb_ready;
    logic [2:0]  wb_rd;
    logic [15:0] wb_data;
    logic        wb_overflow, ovf_sticky, clear_ovf;

    int total = 0;
    int bad   = 0;

    typedef struct packed {
        logic [2:0]  rd;
        logic [15:0] data;
        logic        ovf;
    } rec_t;

    rec_t        sb[$];
    logic [15:0] mrf [8];
    rec_t        exp_r;
    rec_t        got_r;
    logic [16:0] res;

    always #5 clk = ~clk;

    alu_issue_pipe #(.DATA_W(16), .CODE_W(5), .NREG(8)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_ld(in_ld), .in_code(in_code),
        .in_rd(in_rd), .in_rs1(in_rs1), .in_rs2(in_rs2), .in_imm(in_imm),
        .alu_a(alu_a), .alu_b(alu_b), .alu_code(alu_code),
        .alu_c(alu_c), .alu_overflow(alu_overflow),
        .wb_valid(wb_valid), .wb_ready(wb_ready), .wb_rd(wb_rd), .wb_data(wb_data),
        .wb_overflow(wb_overflow), .ovf_sticky(ovf_sticky), .clear_ovf(clear_ovf)
    );

    // 16-bit ALU: add (00000) and sub (00010) with signed overflow, anything else yields 0.
    function automatic logic [16:0] alu_fn(input logic [4:0] code, input logic [15:0] a,
                                           input logic [15:0] b);
        logic [15:0] s;
        logic        v;
        case (code)
            5'b00000: begin s = a + b; v = (a[15] == b[15]) && (s[15] != a[15]); end
            5'b00010: begin s = a - b; v = (a[15] != b[15]) && (s[15] != a[15]); end
            default:  begin s = 16'h0000; v = 1'b0; end
        endcase
        return {v, s};
    endfunction

    always_comb {alu_overflow, alu_c} = alu_fn(alu_code, alu_a, alu_b);

    // Scoreboard: predict on accept, compare on take; both handshakes sampled mid-cycle.
    always @(negedge clk) begin
        if (rst_n) begin
            if (wb_valid && wb_ready) begin
                total++;
                got_r = {wb_rd, wb_data, wb_overflow};
                if (sb.size() == 0) begin
                    bad++;
                    $display("FAIL wb_unexpected: got rd=%0d data=%h ovf=%b, want no record",
                             wb_rd, wb_data, wb_overflow);
                end else begin
                    exp_r = sb.pop_front();
                    if (got_r !== exp_r) begin
                        bad++;
                        $display("FAIL wb_record: got rd=%0d data=%h ovf=%b, want rd=%0d data=%h ovf=%b",
                                 wb_rd, wb_data, wb_overflow, exp_r.rd, exp_r.data, exp_r.ovf);
                    end
                end
            end
            if (in_valid && in_ready) begin
                res = in_ld ? {1'b0, in_imm} : alu_fn(in_code, mrf[in_rs1], mrf[in_rs2]);
                sb.push_back({in_rd, res[15:0], res[16]});
                if (in_rd != 3'd0)
                    mrf[in_rd] = res[15:0];
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic op(input logic ld, input logic [4:0] code, input logic [2:0] rd,
                      input logic [2:0] rs1, input logic [2:0] rs2, input logic [15:0] imm);
        in_valid = 1'b1;
        in_ld    = ld;
        in_code  = code;
        in_rd    = rd;
        in_rs1   = rs1;
        in_rs2   = rs2;
        in_imm   = imm;
    endtask

    task automatic idle();
        in_valid = 1'b0;
    endtask

    task automatic model_clear();
        sb.delete();
        for (int i = 0; i < 8; i++)
            mrf[i] = 16'h0000;
    endtask

    task automatic test_reset();
        op(1, 5'd0, 3'd1, 3'd0, 3'd0, 16'h7FFF); step();
        op(1, 5'd0, 3'd2, 3'd0, 3'd0, 16'h0001); step();
        for (int i = 3; i < 8; i++) begin
            op(1, 5'd0, 3'(i), 3'd0, 3'd0, 16'(16'h1111 * i));
            step();
        end
        op(0, 5'b00000, 3'd3, 3'd1, 3'd2, 16'h0000); step();
        op(1, 5'd0, 3'd6, 3'd0, 3'd0, 16'hABCD); step();
        idle();
        total++;
        if ({wb_valid, ovf_sticky, alu_a} !== {1'b1, 1'b1, 16'hABCD}) begin
            bad++;
            $display("FAIL reset_precond: got wb_valid=%b sticky=%b alu_a=%h, want 1 1 abcd",
                     wb_valid, ovf_sticky, alu_a);
        end
        rst_n = 1'b0;
        #1;
        model_clear();
        total++;
        if ({alu_a, alu_b, alu_code, wb_valid, wb_rd, wb_data, wb_overflow, ovf_sticky} !== '0) begin
            bad++;
            $display("FAIL reset_outputs: got a=%h b=%h code=%h wbv=%b rd=%0d data=%h ovf=%b sticky=%b, want all 0",
                     alu_a, alu_b, alu_code, wb_valid, wb_rd, wb_data, wb_overflow, ovf_sticky);
        end
        total++;
        if (in_ready !== 1'b1) begin
            bad++;
            $display("FAIL reset_in_ready: got %b want 1", in_ready);
        end
        step(); step();
        rst_n = 1'b1;
        step();
        for (int i = 1; i < 8; i++) begin
            op(0, 5'b00000, 3'd0, 3'(i), 3'd0, 16'h0000);
            step();
        end
        idle(); step(); step(); step();
    endtask

    task automatic test_dependent_add();
        op(1, 5'd0, 3'd1, 3'd0, 3'd0, 16'h0005); step();
        op(1, 5'd0, 3'd2, 3'd0, 3'd0, 16'h0003); step();
        total++;
        if (in_ready !== 1'b1) begin
            bad++;
            $display("FAIL dep_no_bubble: in_ready got %b want 1", in_ready);
        end
        op(0, 5'b00000, 3'd3, 3'd1, 3'd2, 16'h0000); step();
        idle(); step();
        total++;
        if ({wb_valid, wb_rd, wb_data} !== {1'b1, 3'd3, 16'h0008}) begin
            bad++;
            $display("FAIL dep_add: got v=%b rd=%0d data=%h, want v=1 rd=3 data=0008",
                     wb_valid, wb_rd, wb_data);
        end
        step();
    endtask

    task automatic test_overflow();
        op(1, 5'd0, 3'd1, 3'd0, 3'd0, 16'h7FFF); step();
        op(1, 5'd0, 3'd2, 3'd0, 3'd0, 16'h0001); step();
        op(0, 5'b00000, 3'd4, 3'd1, 3'd2, 16'h0000); step();
        idle(); step();
        total++;
        if ({wb_data, wb_overflow, ovf_sticky} !== {16'h8000, 1'b1, 1'b1}) begin
            bad++;
            $display("FAIL ovf_add: got data=%h ovf=%b sticky=%b, want 8000 1 1",
                     wb_data, wb_overflow, ovf_sticky);
        end
        clear_ovf = 1'b1; step();
        clear_ovf = 1'b0;
        total++;
        if (ovf_sticky !== 1'b0) begin
            bad++;
            $display("FAIL ovf_clear: sticky got %b want 0", ovf_sticky);
        end
        op(0, 5'b00000, 3'd5, 3'd1, 3'd2, 16'h0000); step();
        idle();
        clear_ovf = 1'b1; step();
        clear_ovf = 1'b0;
        total++;
        if (ovf_sticky !== 1'b1) begin
            bad++;
            $display("FAIL ovf_set_wins: sticky got %b want 1", ovf_sticky);
        end
        step();
    endtask

    task automatic test_backpressure();
        logic [15:0] sa, sb_v, sd;
        logic [2:0]  sr;
        wb_ready = 1'b0;
        op(0, 5'b00000, 3'd6, 3'd1, 3'd2, 16'h0000); step();
        op(0, 5'b00010, 3'd7, 3'd6, 3'd1, 16'h0000); step();
        op(1, 5'd0, 3'd5, 3'd0, 3'd0, 16'h5555);
        sa = alu_a; sb_v = alu_b; sd = wb_data; sr = wb_rd;
        total++;
        if ({wb_valid, wb_rd} !== {1'b1, 3'd6}) begin
            bad++;
            $display("FAIL bp_first: got v=%b rd=%0d, want v=1 rd=6", wb_valid, wb_rd);
        end
        for (int c = 0; c < 3; c++) begin
            total++;
            if (in_ready !== 1'b0) begin
                bad++;
                $display("FAIL bp_in_ready: cycle %0d got %b want 0", c, in_ready);
            end
            step();
            total++;
            if ({alu_a, alu_b, wb_data, wb_rd, wb_valid} !== {sa, sb_v, sd, sr, 1'b1}) begin
                bad++;
                $display("FAIL bp_hold: cycle %0d got a=%h b=%h d=%h rd=%0d v=%b, want a=%h b=%h d=%h rd=%0d v=1",
                         c, alu_a, alu_b, wb_data, wb_rd, wb_valid, sa, sb_v, sd, sr);
            end
        end
        wb_ready = 1'b1;
        step();
        idle();
        total++;
        if ({wb_valid, wb_rd} !== {1'b1, 3'd7}) begin
            bad++;
            $display("FAIL bp_second: got v=%b rd=%0d, want v=1 rd=7", wb_valid, wb_rd);
        end
        step();
        total++;
        if ({wb_valid, wb_rd, wb_data} !== {1'b1, 3'd5, 16'h5555}) begin
            bad++;
            $display("FAIL bp_third: got v=%b rd=%0d data=%h, want v=1 rd=5 data=5555",
                     wb_valid, wb_rd, wb_data);
        end
        step();
        total++;
        if (wb_valid !== 1'b0) begin
            bad++;
            $display("FAIL bp_drain: wb_valid got %b want 0", wb_valid);
        end
    endtask

    task automatic test_r0();
        op(1, 5'd0, 3'd0, 3'd0, 3'd0, 16'h1234); step();
        op(0, 5'b00010, 3'd5, 3'd0, 3'd0, 16'h0000); step();
        op(1, 5'd0, 3'd0, 3'd0, 3'd0, 16'h1234);
        total++;
        if ({wb_valid, wb_rd, wb_data} !== {1'b1, 3'd0, 16'h1234}) begin
            bad++;
            $display("FAIL r0_load: got v=%b rd=%0d data=%h, want v=1 rd=0 data=1234",
                     wb_valid, wb_rd, wb_data);
        end
        step();
        op(0, 5'b00000, 3'd4, 3'd0, 3'd0, 16'h0000); step();
        idle(); step();
        total++;
        if ({wb_rd, wb_data} !== {3'd4, 16'h0000}) begin
            bad++;
            $display("FAIL r0_no_bypass: got rd=%0d data=%h, want rd=4 data=0000", wb_rd, wb_data);
        end
        step();
    endtask

    task automatic test_invalid_code();
        op(1, 5'd0, 3'd3, 3'd0, 3'd0, 16'h00AA); step();
        op(0, 5'b00111, 3'd3, 3'd1, 3'd2, 16'h0000); step();
        idle();
        step();
        total++;
        if ({wb_valid, wb_rd, wb_data} !== {1'b1, 3'd3, 16'h0000}) begin
            bad++;
            $display("FAIL invalid_code: got v=%b rd=%0d data=%h, want v=1 rd=3 data=0000",
                     wb_valid, wb_rd, wb_data);
        end
        step();
        op(0, 5'b00000, 3'd4, 3'd3, 3'd0, 16'h0000); step();
        idle(); step();
        total++;
        if (wb_data !== 16'h0000) begin
            bad++;
            $display("FAIL invalid_written: r3 readback got %h want 0000", wb_data);
        end
        step();
    endtask

    task automatic test_back_to_back();
        logic [4:0] codes [3];
        codes[0] = 5'b00000;
        codes[1] = 5'b00010;
        codes[2] = 5'b00111;
        for (int c = 0; c < 60; c++) begin
            wb_ready = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 4) != 0)
                op(($urandom_range(0, 3) == 0), codes[$urandom_range(0, 2)], 3'($urandom_range(0, 7)),
                   3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)), 16'($urandom));
            else
                idle();
            step();
        end
        idle();
        wb_ready = 1'b1;
        for (int c = 0; c < 6; c++)
            step();
        total++;
        if (sb.size() != 0) begin
            bad++;
            $display("FAIL b2b_drain: %0d records outstanding, want 0", sb.size());
        end
    endtask

    initial begin
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_ld     = 1'b0;
        in_code   = 5'd0;
        in_rd     = 3'd0;
        in_rs1    = 3'd0;
        in_rs2    = 3'd0;
        in_imm    = 16'h0000;
        wb_ready  = 1'b1;
        clear_ovf = 1'b0;
        model_clear();
        step(); step();
        rst_n = 1'b1;
        step();

        test_reset();
        test_dependent_add();
        test_overflow();
        test_backpressure();
        test_r0();
        test_invalid_code();
        test_back_to_back();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
